rom_fetch_ctrl: RTL

Sequencer between the MCU51 core and the single-port byte program ROM (negedge-registered data, active-low CS).
- Assembles 1–3 byte 8051 instructions from consecutive ROM bytes and maintains the fetch PC.
- Shares the ROM with MOVC table reads from the core.
- Issues at most one ROM access per clock and presents complete instructions to the decoder.

---
 rtl/mcu51_pkg.sv | 18 +
 rtl/op_len_decode.sv | 9 +
 rtl/rom_fetch_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/mcu51_pkg.sv
// mcu51_pkg: shared FSM states, ROM timing constant and 8051 opcode length map.
package mcu51_pkg;
  localparam int ROM_LATENCY = 1;
  typedef enum logic [2:0] {IDLE, F_OP, F_B1, F_B2, M_RD} state_t;
  function automatic logic [1:0] op_len(input logic [7:0] op);
    logic l3, l2;
    l3 = op inside {8'h02, 8'h10, 8'h12, 8'h20, 8'h30, 8'h43, 8'h53, 8'h63, 8'h75, 8'h85,
                    8'h90, [8'hB4:8'hBF], 8'hD5};
    // every xx1 opcode is AJMP/ACALL with a one-byte page offset
    l2 = (op[3:0] == 4'h1) ||
         (op inside {8'h05, 8'h15, 8'h24, 8'h25, 8'h34, 8'h35, 8'h40, 8'h42, 8'h44, 8'h45,
                     8'h50, 8'h52, 8'h54, 8'h55, 8'h60, 8'h62, 8'h64, 8'h65, 8'h70, 8'h72,
                     8'h74, [8'h76:8'h80], 8'h82, [8'h86:8'h8F], 8'h92, 8'h94, 8'h95, 8'hA0,
                     8'hA2, [8'hA6:8'hAF], 8'hB0, 8'hB2, 8'hC0, 8'hC2, 8'hC5, 8'hD0, 8'hD2,
                     [8'hD8:8'hDF], 8'hE5, 8'hF5});
    return l3 ? 2'd3 : l2 ? 2'd2 : 2'd1;
  endfunction
endpackage

// File: rtl/op_len_decode.sv
// op_len_decode: combinational 8051 opcode to instruction length (1..3).
module op_len_decode
  import mcu51_pkg::*;
(
  input  logic [7:0] i_op,
  output logic [1:0] o_len
);
  assign o_len = op_len(i_op);
endmodule

// File: rtl/rom_fetch_ctrl.sv
// rom_fetch_ctrl: shares the program ROM between instruction fetch and MOVC reads,
// assembling 1-3 byte instructions one ROM byte per clock.
module rom_fetch_ctrl
  import mcu51_pkg::*;
#(
  parameter int                    ADDRWIDTH = 8,
  parameter logic [ADDRWIDTH-1:0]  RESET_PC  = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fetch_req,
  input  logic                 pc_load,
  input  logic [ADDRWIDTH-1:0] pc_in,
  output logic                 instr_valid,
  output logic [7:0]           instr_op,
  output logic [7:0]           instr_b1,
  output logic [7:0]           instr_b2,
  output logic [1:0]           instr_len,
  output logic [ADDRWIDTH-1:0] instr_pc,
  input  logic                 movc_req,
  input  logic [ADDRWIDTH-1:0] movc_addr,
  output logic                 movc_ack,
  output logic [7:0]           movc_data,
  output logic                 rom_cs_n,
  output logic [ADDRWIDTH-1:0] rom_addr,
  input  logic [7:0]           rom_data
);
  state_t                 r_state, w_state;
  logic [ADDRWIDTH-1:0]   r_pc, w_pc, w_iaddr;
  logic                   r_fetch_pend, w_pend, w_issue, w_fin, w_ack, w_fetch, w_movc;
  logic [7:0]             r_op, r_b1;
  logic [1:0]             r_len, w_len_dec, w_len;
  op_len_decode u_len (.i_op(rom_data), .o_len(w_len_dec));
  assign w_fetch = fetch_req | r_fetch_pend;
  // the request still high during its own ack cycle is the one just served
  assign w_movc  = movc_req & ~movc_ack;
  assign w_len   = (r_state == F_OP) ? w_len_dec : r_len;
  always_comb begin
    w_state = r_state;
    w_pc    = r_pc;
    w_pend  = w_fetch;
    w_issue = 1'b0;
    w_iaddr = r_pc;
    w_fin   = 1'b0;
    w_ack   = 1'b0;
    case (r_state)
      IDLE: begin
        if (pc_load) begin
          w_pc    = pc_in;
          w_iaddr = pc_in;
          w_issue = w_fetch;
          w_pend  = 1'b0;
          w_state = w_fetch ? F_OP : IDLE;
        end else if (w_movc) begin
          w_issue = 1'b1;
          w_iaddr = movc_addr;
          w_state = M_RD;
        end else if (w_fetch) begin
          w_issue = 1'b1;
          w_pend  = 1'b0;
          w_state = F_OP;
        end
      end
      F_OP, F_B1, F_B2: begin
        if (pc_load) begin
          w_pc    = pc_in;
          w_pend  = fetch_req;
          w_state = IDLE;
        end else if (r_state == F_B2 || (r_state == F_OP ? w_len_dec == 2'd1 : r_len == 2'd2)) begin
          w_fin   = 1'b1;
          w_pc    = r_pc + ADDRWIDTH'(w_len);
          w_state = IDLE;
        end else begin
          w_issue = 1'b1;
          w_iaddr = r_pc + ((r_state == F_OP) ? ADDRWIDTH'(1) : ADDRWIDTH'(2));
          w_state = (r_state == F_OP) ? F_B1 : F_B2;
        end
      end
      M_RD: begin
        w_ack   = 1'b1;
        w_pc    = pc_load ? pc_in : r_pc;
        w_iaddr = w_pc;
        w_issue = w_fetch;
        w_pend  = 1'b0;
        w_state = w_fetch ? F_OP : IDLE;
      end
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_fetch_pend <= 1'b0;
      r_op         <= '0;
      r_b1         <= '0;
      r_len        <= '0;
      rom_cs_n     <= 1'b1;
      rom_addr     <= '0;
      instr_valid  <= 1'b0;
      instr_op     <= '0;
      instr_b1     <= '0;
      instr_b2     <= '0;
      instr_len    <= '0;
      instr_pc     <= '0;
      movc_ack     <= 1'b0;
      movc_data    <= '0;
    end else begin
      r_state      <= w_state;
      r_pc         <= w_pc;
      r_fetch_pend <= w_pend;
      rom_cs_n     <= ~w_issue;
      if (w_issue) rom_addr <= w_iaddr;
      if (r_state == F_OP) begin
        r_op  <= rom_data;
        r_len <= w_len_dec;
      end
      if (r_state == F_B1) r_b1 <= rom_data;
      instr_valid <= w_fin;
      movc_ack    <= w_ack;
      if (w_fin) begin
        instr_op  <= (r_state == F_OP) ? rom_data : r_op;
        instr_b1  <= (r_state == F_OP) ? 8'h00 : (r_state == F_B1) ? rom_data : r_b1;
        instr_b2  <= (r_state == F_B2) ? rom_data : 8'h00;
        instr_len <= w_len;
        instr_pc  <= r_pc;
      end
      if (w_ack) movc_data <= rom_data;
    end
  end
endmodule
